instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   Fetch stage directly downstream of the PC register. Reads the current PC and
//   issues one instruction-memory read per instruction. It captures the returned
//   word and presents it to decode with a valid/ready handshake.
//   It drives load/data_in of the PC register (sequential pc+4 or a redirect target).
//   A redirect from execute squashes any wrong-path fetch in flight or held.
// PARAMETERS
//   XLEN        32   address/data width
//   INST_BYTES  4    PC increment per sequential fetch
// PORTS
//   clk          in   1     clock, all state updates on posedge
//   rst          in   1     synchronous, active-high reset
//   pc           in   XLEN  current PC (PC register data_out)
//   pc_load      out  1     load strobe to PC register
//   pc_next      out  XLEN  next PC value (PC register data_in)
//   redirect     in   1     branch/jump redirect from execute
//   redirect_pc  in   XLEN  redirect target
//   imem_read    out  1     memory read request, held until imem_resp
//   imem_address out  XLEN  request address, stable while imem_read=1
//   imem_resp    in   1     single-cycle response strobe, rdata valid same cycle
//   imem_rdata   in   XLEN  returned instruction word
//   inst_valid   out  1     instruction available to decode
//   inst_ready   in   1     decode accepts instruction
//   inst         out  XLEN  instruction word
//   inst_pc      out  XLEN  PC of instruction
// BEHAVIOUR
//   Reset
//     - Enter IDLE. squash=0.
//     - imem_read, pc_load, inst_valid = 0; imem_address, inst, inst_pc, pc_next = 0.
//   FSM states: IDLE, WAIT, HOLD.
//   IDLE
//     - Latch req_addr<=pc and go to WAIT.
//     - First request is asserted the cycle after reset deasserts.
//   WAIT
//     - imem_read=1; imem_address=req_addr (registered, never changes mid-request).
//     - resp & ~squash & ~redirect: inst<=rdata, inst_pc<=req_addr;
//       pc_load=1, pc_next=req_addr+INST_BYTES; go to HOLD.
//     - redirect (no resp): pc_load=1, pc_next=redirect_pc; squash<=1; stay in WAIT.
//     - resp & (squash | redirect): discard data; squash<=0; go to IDLE.
//       If redirect is asserted, also pc_load=1, pc_next=redirect_pc (redirect wins).
//   HOLD
//     - inst_valid = ~redirect (combinational mask; a held word is wrong-path on redirect).
//     - inst_ready & ~redirect: handshake completes; req_addr<=pc; go to WAIT.
//     - redirect: pc_load=1, pc_next=redirect_pc; go to IDLE. Held word is dropped
//       regardless of inst_ready.
//     - Otherwise hold: inst and inst_pc stable.
//   Rules
//     - pc_load is combinational, asserted only in the cases above; 0 otherwise.
//     - pc_next[1:0] is forced to 2'b00; redirect_pc low bits are ignored.
//     - pc+INST_BYTES wraps modulo 2^XLEN: 0xFFFF_FFFC -> 0x0000_0000.
//     - Throughput: at most one fetch per 2 cycles plus memory latency; no overlapping requests.
//     - Reset mid-request: abandon the request. imem_read=0 on the next cycle.
//       A late imem_resp after reset is ignored (IDLE).
//   Latency
//     - IDLE->request: 1 cycle.
//     - resp -> inst_valid: 1 cycle.
//     - accept -> next request: 1 cycle.
// TESTING
//   1. Reset; PC reg=0x4000_0000; mem resp 1 cycle later with 0x0000_0013
//      -> imem_address=0x4000_0000; inst=0x13, inst_pc=0x4000_0000; pc_load with pc_next=0x4000_0004.
//   2. inst_ready low 3 cycles in HOLD -> inst/inst_pc stable, no new imem_read;
//      ready high -> next request to 0x4000_0004.
//   3. Redirect to 0x4000_0100 two cycles before resp
//      -> imem_address unchanged until resp; data discarded; next request 0x4000_0100.
//   4. Redirect in the same cycle as imem_resp -> no inst_valid; pc_next=redirect_pc;
//      next fetch at the target.
//   5. pc=0xFFFF_FFFC fetched -> pc_next=0x0000_0000. redirect_pc=0x4000_0102 -> pc_next=0x4000_0100.
//   6. Redirect in HOLD with inst_ready=1 -> inst_valid=0 that cycle, FSM to IDLE.
//      rst asserted in WAIT -> imem_read=0 next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage sitting directly after the PC register. It issues one
//   instruction-memory read per instruction and captures the returned word.
//   The word is offered to decode with a valid/ready handshake.
//   The stage also drives the PC register's load strobe and its next value.
//   That value is either the sequential pc+INST_BYTES or a redirect target
//   from execute. A redirect squashes any wrong-path fetch that is still in
//   flight or already held.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   pc              current PC (PC register output)
//   pc_load/pc_next load strobe and data for the PC register
//   redirect/_pc    branch/jump redirect and its target
//   imem_*          memory request (held until imem_resp) and response
//   inst_valid/     instruction handshake towards decode
//   inst_ready
//   inst/inst_pc    instruction word and its address
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int XLEN       = 32,
    parameter int INST_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_read,
    output logic [XLEN-1:0] imem_address,
    input  logic            imem_resp,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state_reg, state_next;
    logic            squash_reg, squash_next;
    logic [XLEN-1:0] req_addr_reg, req_addr_next;
    logic [XLEN-1:0] inst_reg, inst_next;
    logic [XLEN-1:0] inst_pc_reg, inst_pc_next;
    logic [XLEN-1:0] target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            squash_reg   <= 1'b0;
            req_addr_reg <= '0;
            inst_reg     <= '0;
            inst_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            squash_reg   <= squash_next;
            req_addr_reg <= req_addr_next;
            inst_reg     <= inst_next;
            inst_pc_reg  <= inst_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        squash_next   = squash_reg;
        req_addr_next = req_addr_reg;
        inst_next     = inst_reg;
        inst_pc_next  = inst_pc_reg;
        pc_load       = 1'b0;
        target        = '0;
        imem_read     = 1'b0;
        inst_valid    = 1'b0;

        case (state_reg)
            IDLE: begin
                req_addr_next = pc;
                state_next    = WAIT;
            end
            WAIT: begin
                imem_read = 1'b1;
                if (imem_resp) begin
                    if (squash_reg || redirect) begin
                        // Wrong-path word: drop it and refetch from the PC,
                        // which by then holds the redirect target.
                        squash_next = 1'b0;
                        state_next  = IDLE;
                        if (redirect) begin
                            pc_load = 1'b1;
                            target  = redirect_pc;
                        end
                    end else begin
                        inst_next    = imem_rdata;
                        inst_pc_next = req_addr_reg;
                        pc_load      = 1'b1;
                        target       = req_addr_reg + INC;
                        state_next   = HOLD;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn mid-flight, so we
                    // remember to discard its response.
                    pc_load     = 1'b1;
                    target      = redirect_pc;
                    squash_next = 1'b1;
                end
            end
            HOLD: begin
                // A held word is already wrong-path while redirect is high.
                inst_valid = ~redirect;
                if (redirect) begin
                    pc_load    = 1'b1;
                    target     = redirect_pc;
                    state_next = IDLE;
                end else if (inst_ready) begin
                    req_addr_next = pc;
                    state_next    = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Instructions are word aligned: the low two address bits are always zero.
    assign pc_next      = pc_load ? {target[XLEN-1:2], 2'b00} : '0;
    assign imem_address = req_addr_reg;
    assign inst         = inst_reg;
    assign inst_pc      = inst_pc_reg;

endmodule
